// File: rtl/sram_dwsn_resp_if.sv
// sram_dwsn_resp_if
//   Physical-side bus of the aligned-word SRAM macro.
//
//   Handshake: mem_read and mem_write are single-cycle strobes sampled on every
//   rising clk edge. There is no ready/backpressure: the responder accepts one
//   read and one write in every cycle. mem_dout returns read data a fixed number
//   of cycles after the read strobe. seg_rdy and viol are registered status.
//
//   master : drives mem_read, mem_write, mem_addr, mem_bw, mem_dwsn, mem_din
//            and receives mem_dout, seg_rdy, viol
//   slave  : the macro side (sram_dwsn_resp)
interface sram_dwsn_resp_if #(
    parameter int BITSROW = 8,
    parameter int DWIDTH  = 264,
    parameter int BITDWSN = 4
);
    logic               mem_read;
    logic               mem_write;
    logic [BITSROW-1:0] mem_addr;
    logic [DWIDTH-1:0]  mem_bw;
    logic [BITDWSN-1:0] mem_dwsn;
    logic [DWIDTH-1:0]  mem_din;
    logic [DWIDTH-1:0]  mem_dout;
    logic [BITDWSN-1:0] seg_rdy;
    logic               viol;

    modport master (
        output mem_read, mem_write, mem_addr, mem_bw, mem_dwsn, mem_din,
        input  mem_dout, seg_rdy, viol
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_bw, mem_dwsn, mem_din,
        output mem_dout, seg_rdy, viol
    );
endinterface

// File: rtl/sram_dwsn_resp.sv
// sram_dwsn_resp
//   Behavioural responder for the physical side of the aligned-word SRAM.
//   Stores rows of DWIDTH bits split into BITDWSN deep-sleep segments, returns
//   read data SRAM_DELAY edges after the read strobe, tracks per-segment
//   wake-up (SLEEP/WAKE/ACTIVE) and pulses viol on illegal accesses.
//
//   Ports:
//     clk    : clock
//     rst_n  : asynchronous active-low reset
//     bus    : sram_dwsn_resp_if.slave
//              mem_read/mem_write strobes, mem_addr row, mem_bw bit write
//              enables, mem_dwsn per-segment sleep (1=asleep), mem_din data,
//              mem_dout read data, seg_rdy per-segment ACTIVE, viol pulse
//
//   Optional build macro SRAM_DWSN_NORET_EN:
//     defined   - contents are lost when a segment sleeps; a per-row,
//                 per-segment valid array masks stale data to zero.
//     undefined - contents retained through sleep and reset.
module sram_dwsn_resp #(
    parameter int NUMSROW    = 256,
    parameter int BITSROW    = 8,
    parameter int SEGWDTH    = 66,
    parameter int BITDWSN    = 4,
    parameter int DWIDTH     = 264,
    parameter int SRAM_DELAY = 2,
    parameter int WAKEDLY    = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    sram_dwsn_resp_if.slave bus
);

    typedef enum logic [1:0] {
        SEG_SLEEP  = 2'd0,
        SEG_WAKE   = 2'd1,
        SEG_ACTIVE = 2'd2
    } seg_state_e;

    localparam int CNTW   = (WAKEDLY > 1) ? $clog2(WAKEDLY) : 1;
    localparam int PDEPTH = (SRAM_DELAY > 1) ? SRAM_DELAY - 1 : 1;
    localparam logic [CNTW-1:0]  WAKE_LOAD = (WAKEDLY > 0) ? CNTW'(WAKEDLY - 1) : '0;
    localparam logic [BITSROW:0] NUMSROW_W = (BITSROW + 1)'(NUMSROW);

    // Storage (not reset: contents survive reset)
    logic [DWIDTH-1:0]  mem_q [NUMSROW];

    // Segment FSMs
    seg_state_e         seg_state_q [BITDWSN];
    logic [CNTW-1:0]    wake_cnt_q  [BITDWSN];
    logic [BITDWSN-1:0] seg_rdy_q;

    // Read pipeline: PDEPTH stages feed the mem_dout holding register
    logic [PDEPTH-1:0]  pipe_vld_q;
    logic [DWIDTH-1:0]  pipe_dat_q [PDEPTH];
    logic [DWIDTH-1:0]  dout_q;
    logic               viol_q;

    // Combinational decode
    logic               addr_ok;
    logic [BITDWSN-1:0] seg_acc;
    logic [BITDWSN-1:0] seg_waking;
    logic [BITDWSN-1:0] rd_seg_en;
    logic [DWIDTH-1:0]  acc_bits;
    logic [DWIDTH-1:0]  rd_bits;
    logic [DWIDTH-1:0]  wmask;
    logic [DWIDTH-1:0]  rd_data_d;
    logic               viol_d;

`ifdef SRAM_DWSN_NORET_EN
    logic [BITDWSN-1:0] valid_q [NUMSROW];
    logic [BITDWSN-1:0] seg_sleep_evt;
    logic [BITDWSN-1:0] seg_touch;
`endif

    assign addr_ok = ({1'b0, bus.mem_addr} < NUMSROW_W);

    always_comb begin
        seg_acc    = '0;
        seg_waking = '0;
        for (int i = 0; i < BITDWSN; i++) begin
            // With no wake delay a segment is usable in the very cycle dwsn falls.
            seg_acc[i]    = !bus.mem_dwsn[i] &&
                            ((seg_state_q[i] == SEG_ACTIVE) || (WAKEDLY == 0));
            seg_waking[i] = !bus.mem_dwsn[i] && !seg_acc[i];
        end
    end

`ifdef SRAM_DWSN_NORET_EN
    always_comb begin
        seg_sleep_evt = '0;
        for (int i = 0; i < BITDWSN; i++) begin
            seg_sleep_evt[i] = bus.mem_dwsn[i] && (seg_state_q[i] == SEG_ACTIVE);
        end
    end

    always_comb begin
        seg_touch = '0;
        for (int i = 0; i < BITDWSN; i++) begin
            seg_touch[i] = |wmask[i*SEGWDTH +: SEGWDTH];
        end
    end

    assign rd_seg_en = seg_acc & (addr_ok ? valid_q[bus.mem_addr] : '0);
`else
    assign rd_seg_en = seg_acc;
`endif

    always_comb begin
        acc_bits = '0;
        rd_bits  = '0;
        for (int i = 0; i < BITDWSN; i++) begin
            acc_bits[i*SEGWDTH +: SEGWDTH] = {SEGWDTH{seg_acc[i]}};
            rd_bits[i*SEGWDTH +: SEGWDTH]  = {SEGWDTH{rd_seg_en[i]}};
        end
    end

    always_comb begin
        wmask     = bus.mem_bw & acc_bits;
        // Sampled before the same-edge write, so read+write returns old data.
        rd_data_d = addr_ok ? (mem_q[bus.mem_addr] & rd_bits) : '0;
        viol_d    = (bus.mem_write && ((|(bus.mem_bw & ~acc_bits)) || !addr_ok)) ||
                    (bus.mem_read  && ((|seg_waking) || !addr_ok));
    end

    // Array write: only enabled bits in accessible segments of a legal row.
    always_ff @(posedge clk) begin
        if (bus.mem_write && addr_ok) begin
            mem_q[bus.mem_addr] <= (mem_q[bus.mem_addr] & ~wmask) | (bus.mem_din & wmask);
        end
    end

`ifdef SRAM_DWSN_NORET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUMSROW; r++) valid_q[r] <= '0;
        end else begin
            for (int r = 0; r < NUMSROW; r++) begin
                for (int i = 0; i < BITDWSN; i++) begin
                    if (seg_sleep_evt[i]) valid_q[r][i] <= 1'b0;
                end
            end
            // A sleeping segment is never writable, so set and clear never collide.
            if (bus.mem_write && addr_ok) begin
                for (int i = 0; i < BITDWSN; i++) begin
                    if (seg_touch[i]) valid_q[bus.mem_addr][i] <= 1'b1;
                end
            end
        end
    end
`endif

    // Per-segment wake FSM with registered ACTIVE flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BITDWSN; i++) begin
                seg_state_q[i] <= SEG_SLEEP;
                wake_cnt_q[i]  <= '0;
            end
            seg_rdy_q <= '0;
        end else begin
            for (int i = 0; i < BITDWSN; i++) begin
                case (seg_state_q[i])
                    SEG_SLEEP: begin
                        if (!bus.mem_dwsn[i]) begin
                            if (WAKEDLY == 0) begin
                                seg_state_q[i] <= SEG_ACTIVE;
                                seg_rdy_q[i]   <= 1'b1;
                            end else begin
                                seg_state_q[i] <= SEG_WAKE;
                                wake_cnt_q[i]  <= WAKE_LOAD;
                            end
                        end
                    end
                    SEG_WAKE: begin
                        if (bus.mem_dwsn[i]) begin
                            seg_state_q[i] <= SEG_SLEEP;
                        end else if (wake_cnt_q[i] == '0) begin
                            seg_state_q[i] <= SEG_ACTIVE;
                            seg_rdy_q[i]   <= 1'b1;
                        end else begin
                            wake_cnt_q[i] <= wake_cnt_q[i] - CNTW'(1);
                        end
                    end
                    SEG_ACTIVE: begin
                        if (bus.mem_dwsn[i]) begin
                            seg_state_q[i] <= SEG_SLEEP;
                            seg_rdy_q[i]   <= 1'b0;
                        end
                    end
                    default: begin
                        seg_state_q[i] <= SEG_SLEEP;
                        seg_rdy_q[i]   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Read pipeline and violation flag. mem_dout only changes when a read
    // reaches the end of the pipe, so it holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            for (int k = 0; k < PDEPTH; k++) pipe_dat_q[k] <= '0;
            dout_q <= '0;
            viol_q <= 1'b0;
        end else begin
            viol_q <= viol_d;
            if (SRAM_DELAY == 1) begin
                if (bus.mem_read) dout_q <= rd_data_d;
            end else begin
                pipe_vld_q[0] <= bus.mem_read;
                pipe_dat_q[0] <= rd_data_d;
                for (int k = 1; k < PDEPTH; k++) begin
                    pipe_vld_q[k] <= pipe_vld_q[k-1];
                    pipe_dat_q[k] <= pipe_dat_q[k-1];
                end
                if (pipe_vld_q[PDEPTH-1]) dout_q <= pipe_dat_q[PDEPTH-1];
            end
        end
    end

    assign bus.mem_dout = dout_q;
    assign bus.seg_rdy  = seg_rdy_q;
    assign bus.viol     = viol_q;

endmodule

// File: tb/tb_sram_dwsn_resp.sv
// tb_sram_dwsn_resp
//   dut_a: default parameters (WAKEDLY=0, SRAM_DELAY=2), checked every cycle
//          against a reference model and by a directed vector table.
//   dut_b: NUMSROW=200, SRAM_DELAY=1, WAKEDLY=2, hand-written wake and
//          out-of-range sequences.
module tb_sram_dwsn_resp;

  localparam int DW  = 264;
  localparam int SEG = 66;
  localparam int D_A = 2;

  logic clk;
  logic rst_n;

  sram_dwsn_resp_if #(.BITSROW(8), .DWIDTH(DW), .BITDWSN(4)) bus_a ();
  sram_dwsn_resp_if #(.BITSROW(8), .DWIDTH(DW), .BITDWSN(4)) bus_b ();

  sram_dwsn_resp dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  sram_dwsn_resp #(.NUMSROW(200), .SRAM_DELAY(1), .WAKEDLY(2))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // reference model state for dut_a
  logic [DW-1:0] ref_mem   [256];
  logic [3:0]    ref_valid [256];
  logic [3:0]    ref_active;
  logic [DW:0]   exp_q [$];
  logic [DW-1:0] exp_dout;

  logic [DW-1:0] ones, pa5, p3c, r5b, r5_after_rst, r5_half, p7_exp;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [7:0]    addr;
    logic [DW-1:0] bw;
    logic [3:0]    dwsn;
    logic [DW-1:0] din;
    logic          chk;
    logic [DW-1:0] exp_dout;
    logic          exp_viol;
  } vec_t;

  vec_t vecs [$];

  function automatic logic [DW-1:0] seg_mask(input int i);
    logic [DW-1:0] m;
    m = '0;
    m[i*SEG +: SEG] = '1;
    return m;
  endfunction

  function automatic logic [DW-1:0] expand(input logic [3:0] s);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*SEG +: SEG] = {SEG{s[i]}};
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_dw();
    logic [287:0] t;
    for (int k = 0; k < 9; k++) t[k*32 +: 32] = $urandom;
    return t[DW-1:0];
  endfunction

  function automatic vec_t mk(input logic rd, input logic wr, input logic [7:0] addr,
                              input logic [DW-1:0] bw, input logic [3:0] dwsn,
                              input logic [DW-1:0] din, input logic chk,
                              input logic [DW-1:0] ed, input logic ev);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.bw = bw; v.dwsn = dwsn; v.din = din;
    v.chk = chk; v.exp_dout = ed; v.exp_viol = ev;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_a(input logic rd, input logic wr, input logic [7:0] addr,
                       input logic [DW-1:0] bw, input logic [3:0] dwsn, input logic [DW-1:0] din);
    bus_a.mem_read = rd; bus_a.mem_write = wr; bus_a.mem_addr = addr;
    bus_a.mem_bw = bw; bus_a.mem_dwsn = dwsn; bus_a.mem_din = din;
  endtask

  task automatic set_b(input logic rd, input logic wr, input logic [7:0] addr,
                       input logic [DW-1:0] bw, input logic [3:0] dwsn, input logic [DW-1:0] din);
    bus_b.mem_read = rd; bus_b.mem_write = wr; bus_b.mem_addr = addr;
    bus_b.mem_bw = bw; bus_b.mem_dwsn = dwsn; bus_b.mem_din = din;
  endtask

  // One clock cycle: model dut_a's current inputs, advance, compare dut_a.
  task automatic tick();
    logic [3:0]    acc;
    logic [DW-1:0] accb, vmask, rdv, wm;
    logic          ev;
    logic [DW:0]   e;
    // WAKEDLY=0: a segment is usable exactly when its dwsn is low.
    acc   = ~bus_a.mem_dwsn;
    accb  = expand(acc);
`ifdef SRAM_DWSN_NORET_EN
    vmask = expand(ref_valid[bus_a.mem_addr]);
`else
    vmask = '1;
`endif
    rdv = ref_mem[bus_a.mem_addr] & accb & vmask;
    ev  = bus_a.mem_write && (|(bus_a.mem_bw & ~accb));
    exp_q.push_back({bus_a.mem_read, rdv});
    wm = bus_a.mem_bw & accb;
    if (bus_a.mem_write)
      ref_mem[bus_a.mem_addr] = (ref_mem[bus_a.mem_addr] & ~wm) | (bus_a.mem_din & wm);
    for (int i = 0; i < 4; i++) begin
      if (ref_active[i] && bus_a.mem_dwsn[i])
        for (int r = 0; r < 256; r++) ref_valid[r][i] = 1'b0;
      if (bus_a.mem_write && (|wm[i*SEG +: SEG])) ref_valid[bus_a.mem_addr][i] = 1'b1;
    end
    ref_active = acc;
    @(posedge clk);
    #1;
    if (exp_q.size() >= D_A) begin
      e = exp_q.pop_front();
      if (e[DW]) exp_dout = e[DW-1:0];
    end
    chk("a_dout", bus_a.mem_dout, exp_dout);
    chk("a_viol", DW'(bus_a.viol), DW'(ev));
    chk("a_seg_rdy", DW'(bus_a.seg_rdy), DW'(ref_active));
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_dout   = '0;
    ref_active = '0;
    for (int r = 0; r < 256; r++) ref_valid[r] = '0;
    chk("rst_a_dout", bus_a.mem_dout, '0);
    chk("rst_a_rdy_viol", DW'({bus_a.seg_rdy, bus_a.viol}), '0);
    chk("rst_b_dout", bus_b.mem_dout, '0);
    chk("rst_b_rdy_viol", DW'({bus_b.seg_rdy, bus_b.viol}), '0);
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_hold_a", DW'({bus_a.seg_rdy, bus_a.viol}) | bus_a.mem_dout, '0);
    chk("rst_hold_b", DW'({bus_b.seg_rdy, bus_b.viol}) | bus_b.mem_dout, '0);
    rst_n = 1'b1;
  endtask

  initial begin
    ones = '1;
    pa5  = {33{8'hA5}};
    p3c  = {33{8'h3C}};
`ifdef SRAM_DWSN_NORET_EN
    r5_half      = '0;
    r5b          = ones & ~seg_mask(1);
    r5_after_rst = '0;
    p7_exp       = '0;
`else
    r5_half      = pa5 & ~seg_mask(1);
    r5b          = (ones & ~seg_mask(1)) | (pa5 & seg_mask(1));
    r5_after_rst = r5b;
    p7_exp       = p3c;
`endif

    set_a(0, 0, 0, '0, 4'h0, '0);
    set_b(0, 0, 0, '0, 4'h0, '0);
    do_reset(3);

    // directed vectors: {rd, wr, addr, bw, dwsn, din, chk, exp_dout, exp_viol}
    vecs.push_back(mk(0, 1, 5, ones, 4'h0, pa5, 1, '0, 0));
    vecs.push_back(mk(1, 0, 5, '0, 4'h0, '0, 1, '0, 0));
    vecs.push_back(mk(0, 0, 0, '0, 4'h0, '0, 1, pa5, 0));
    vecs.push_back(mk(0, 0, 0, '0, 4'h0, '0, 1, pa5, 0));
    vecs.push_back(mk(0, 1, 3, ones, 4'h0, ones, 0, '0, 0));
    vecs.push_back(mk(0, 1, 3, seg_mask(0), 4'h0, '0, 0, '0, 0));
    vecs.push_back(mk(1, 0, 3, '0, 4'h0, '0, 1, pa5, 0));
    vecs.push_back(mk(0, 0, 0, '0, 4'h0, '0, 1, ones & ~seg_mask(0), 0));
    vecs.push_back(mk(0, 1, 7, ones, 4'h0, p3c, 0, '0, 0));
    vecs.push_back(mk(0, 0, 0, '0, 4'hF, '0, 0, '0, 0));
    vecs.push_back(mk(0, 0, 0, '0, 4'hF, '0, 0, '0, 0));
    vecs.push_back(mk(1, 0, 7, '0, 4'h0, '0, 0, '0, 0));
    vecs.push_back(mk(0, 0, 0, '0, 4'h0, '0, 1, p7_exp, 0));
    vecs.push_back(mk(0, 1, 9, ones, 4'h0, DW'(1), 0, '0, 0));
    vecs.push_back(mk(1, 1, 9, ones, 4'h0, DW'(2), 0, '0, 0));
    vecs.push_back(mk(1, 0, 9, '0, 4'h0, '0, 1, DW'(1), 0));
    vecs.push_back(mk(0, 0, 0, '0, 4'h0, '0, 1, DW'(2), 0));
    vecs.push_back(mk(1, 0, 5, '0, 4'h2, '0, 1, DW'(2), 0));
    vecs.push_back(mk(0, 0, 0, '0, 4'h2, '0, 1, r5_half, 0));
    vecs.push_back(mk(0, 1, 5, ones, 4'h2, ones, 0, '0, 1));
    vecs.push_back(mk(1, 0, 5, '0, 4'h0, '0, 0, '0, 0));
    vecs.push_back(mk(0, 0, 0, '0, 4'h0, '0, 1, r5b, 0));
    vecs.push_back(mk(0, 1, 7, ones, 4'h0, p3c, 0, '0, 0));
    vecs.push_back(mk(1, 0, 7, '0, 4'h0, '0, 0, '0, 0));
    vecs.push_back(mk(0, 0, 0, '0, 4'h0, '0, 1, p3c, 0));

    for (int n = 0; n < vecs.size(); n++) begin
      set_a(vecs[n].rd, vecs[n].wr, vecs[n].addr, vecs[n].bw, vecs[n].dwsn, vecs[n].din);
      tick();
      chk($sformatf("vec%0d_viol", n), DW'(bus_a.viol), DW'(vecs[n].exp_viol));
      if (vecs[n].chk) chk($sformatf("vec%0d_dout", n), bus_a.mem_dout, vecs[n].exp_dout);
    end
    set_a(0, 0, 0, '0, 4'h0, '0);

    // dut_b: wake-delay and out-of-range sequence
    chk("b_all_active", DW'(bus_b.seg_rdy), DW'(4'hF));
    set_b(0, 1, 4, ones, 4'h0, ones); tick();
    chk("b_wr_ok", DW'(bus_b.viol), '0);
    set_b(0, 0, 0, '0, 4'h2, '0); tick();
    chk("b_seg1_sleep", DW'(bus_b.seg_rdy), DW'(4'hD));
    tick();
    set_b(0, 1, 4, seg_mask(1), 4'h0, '0); tick();
    chk("b_wr_waking_viol", DW'(bus_b.viol), DW'(1));
    set_b(1, 0, 4, '0, 4'h0, '0); tick();
    chk("b_rd_waking_viol", DW'(bus_b.viol), DW'(1));
    chk("b_rd_waking_data", bus_b.mem_dout, ones & ~seg_mask(1));
    chk("b_still_waking", DW'(bus_b.seg_rdy), DW'(4'hD));
    set_b(0, 0, 0, '0, 4'h0, '0); tick();
    chk("b_awake", DW'(bus_b.seg_rdy), DW'(4'hF));
    chk("b_viol_pulse_end", DW'(bus_b.viol), '0);
    set_b(0, 1, 4, seg_mask(1), 4'h0, pa5); tick();
    chk("b_wr_awake_ok", DW'(bus_b.viol), '0);
    set_b(1, 0, 4, '0, 4'h0, '0); tick();
    chk("b_rd_data", bus_b.mem_dout, (ones & ~seg_mask(1)) | (pa5 & seg_mask(1)));
    chk("b_rd_ok", DW'(bus_b.viol), '0);
    set_b(1, 0, 200, '0, 4'h0, '0); tick();
    chk("b_oob_rd_viol", DW'(bus_b.viol), DW'(1));
    chk("b_oob_rd_zero", bus_b.mem_dout, '0);
    set_b(0, 1, 255, ones, 4'h0, ones); tick();
    chk("b_oob_wr_viol", DW'(bus_b.viol), DW'(1));
    set_b(0, 0, 0, '0, 4'h0, '0); tick();
    chk("b_idle_viol", DW'(bus_b.viol), '0);
    chk("b_idle_hold", bus_b.mem_dout, '0);

    // reset one cycle after a read: in-flight data is dropped
    set_a(1, 0, 5, '0, 4'h0, '0); tick();
    set_a(0, 0, 0, '0, 4'h0, '0);
    do_reset(2);
    tick();
    chk("post_rst_dout", bus_a.mem_dout, '0);
    set_a(1, 0, 5, '0, 4'h0, '0); tick();
    set_a(0, 0, 0, '0, 4'h0, '0); tick();
    chk("post_rst_row5", bus_a.mem_dout, r5_after_rst);

    // randomized traffic against the model
    for (int r = 0; r < 8; r++) begin
      set_a(0, 1, 8'(r), ones, 4'h0, rand_dw()); tick();
    end
    for (int n = 0; n < 300; n++) begin
      logic [DW-1:0] bw;
      case ($urandom_range(0, 3))
        0: bw = ones;
        1: bw = seg_mask($urandom_range(0, 3));
        2: bw = rand_dw();
        default: bw = '0;
      endcase
      set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), bw,
            ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0, rand_dw());
      tick();
    end
    set_a(0, 0, 0, '0, 4'h0, '0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
